// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin arbiter driving the shared 4-bit 2:1 mux
// Optional: MUX_ARB_FIXED_PRIO_EN gives A fixed priority on ties and at window expiry.
module mux_arbiter #(
  parameter int HOLD_CYCLES = 2,
  parameter int WIDTH       = 4
) (
  input  logic             clk,
  input  logic             Reset_L,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             S4,
  output logic             Reset_L4,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic       LAST_A   = 1'b0;
  localparam logic       LAST_B   = 1'b1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             s4_q, s4_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             tie_to_a;

  // Who wins a contested decision: round-robin on last, or A always.
`ifdef MUX_ARB_FIXED_PRIO_EN
  assign tie_to_a = 1'b1;
`else
  assign tie_to_a = (last_q == LAST_B);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (req_a && req_b) state_d = tie_to_a ? GRANT_A : GRANT_B;
        else if (req_a)     state_d = GRANT_A;
        else if (req_b)     state_d = GRANT_B;
      end
      GRANT_A: begin
        if (!req_a) begin
          state_d = req_b ? GRANT_B : IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
          state_d = GRANT_A;
`else
          state_d = req_b ? GRANT_B : GRANT_A;
`endif
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_d = req_a ? GRANT_A : IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = req_a ? GRANT_A : GRANT_B;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // last and S4 follow the grant being entered; S4 holds through IDLE.
  always_comb begin
    last_d = last_q;
    s4_d   = s4_q;
    if (state_d == GRANT_A) begin
      last_d = LAST_A;
      s4_d   = 1'b0;
    end else if (state_d == GRANT_B) begin
      last_d = LAST_B;
      s4_d   = 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (state_q == GRANT_A && req_a) begin
      data_d  = data_a;
      valid_d = 1'b1;
    end else if (state_q == GRANT_B && req_b) begin
      data_d  = data_b;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= LAST_B;
      s4_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      s4_q    <= s4_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt_a     = (state_q == GRANT_A);
  assign gnt_b     = (state_q == GRANT_B);
  assign Reset_L4  = gnt_a | gnt_b;
  assign S4        = s4_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter (HOLD_CYCLES = 2)
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       Reset_L;
  logic       req_a, req_b;
  logic [3:0] data_a, data_b;
  logic       gnt_a, gnt_b, S4, Reset_L4, valid_out;
  logic [3:0] data_out;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.HOLD_CYCLES(2), .WIDTH(4)) dut (
    .clk(clk), .Reset_L(Reset_L), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .S4(S4), .Reset_L4(Reset_L4), .data_out(data_out), .valid_out(valid_out)
  );

  // Observed bundle: {gnt_a, gnt_b, S4, Reset_L4, valid_out, data_out}
  function automatic logic [8:0] obs();
    return {gnt_a, gnt_b, S4, Reset_L4, valid_out, data_out};
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset_L = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    edge_step();
    edge_step();
    Reset_L = 1'b1;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    data_a = 4'hF; data_b = 4'hF;
    edge_step();
    edge_step();
    vectors++;
    if (obs() !== 9'b0_0_0_0_0_0000) begin
      $display("FAIL reset_hold: got %b expected %b", obs(), 9'b0);
      errors++;
    end
    Reset_L = 1'b1;
    edge_step();
    vectors++;
    if (obs() !== 9'b1_0_0_1_0_0000) begin
      $display("FAIL reset_release_first_grant: got %b expected %b", obs(), 9'b1_0_0_1_0_0000);
      errors++;
    end
  endtask

  task automatic test_single_a();
    logic [8:0] exp;
    apply_reset();
    data_a = 4'b1010; data_b = 4'b0000;
    req_a = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      edge_step();
      exp = (e == 1) ? 9'b1_0_0_1_0_0000 : 9'b1_0_0_1_1_1010;
      vectors++;
      if (obs() !== exp) begin
        $display("FAIL single_a edge %0d: got %b expected %b", e, obs(), exp);
        errors++;
      end
    end
  endtask

  task automatic test_contention();
    logic [8:0] exp_tbl [6];
    exp_tbl[0] = 9'b1_0_0_1_0_0000;
    exp_tbl[1] = 9'b1_0_0_1_1_0110;
    exp_tbl[2] = 9'b0_1_1_1_1_0110;
    exp_tbl[3] = 9'b0_1_1_1_1_1001;
    exp_tbl[4] = 9'b1_0_0_1_1_1001;
    exp_tbl[5] = 9'b1_0_0_1_1_0110;
    apply_reset();
    data_a = 4'b0110; data_b = 4'b1001;
    req_a = 1'b1; req_b = 1'b1;
    for (int e = 0; e < 6; e++) begin
      edge_step();
      vectors++;
      if (obs() !== exp_tbl[e]) begin
        $display("FAIL contention edge %0d: got %b expected %b", e + 1, obs(), exp_tbl[e]);
        errors++;
      end
    end
  endtask

  task automatic test_drop_and_async_reset();
    apply_reset();
    data_a = 4'b0011; data_b = 4'b0101;
    req_a = 1'b1; req_b = 1'b1;
    edge_step();
    vectors++;
    if (obs() !== 9'b1_0_0_1_0_0000) begin
      $display("FAIL drop_grant_a: got %b expected %b", obs(), 9'b1_0_0_1_0_0000);
      errors++;
    end
    req_a = 1'b0;
    edge_step();
    vectors++;
    if (obs() !== 9'b0_1_1_1_0_0000) begin
      $display("FAIL drop_handover: got %b expected %b", obs(), 9'b0_1_1_1_0_0000);
      errors++;
    end
    edge_step();
    vectors++;
    if (obs() !== 9'b0_1_1_1_1_0101) begin
      $display("FAIL drop_b_capture: got %b expected %b", obs(), 9'b0_1_1_1_1_0101);
      errors++;
    end
    #2;
    Reset_L = 1'b0;
    #1;
    vectors++;
    if (obs() !== 9'b0) begin
      $display("FAIL async_reset_mid_b: got %b expected %b", obs(), 9'b0);
      errors++;
    end
    edge_step();
    Reset_L = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    edge_step();
    vectors++;
    if (obs() !== 9'b1_0_0_1_0_0000) begin
      $display("FAIL post_reset_tie: got %b expected %b", obs(), 9'b1_0_0_1_0_0000);
      errors++;
    end
  endtask

`ifdef MUX_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    apply_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      edge_step();
      vectors++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
        $display("FAIL fixed_prio edge %0d: got gnt_a=%b gnt_b=%b expected 1 0", e, gnt_a, gnt_b);
        errors++;
      end
    end
  endtask
`endif

  initial begin
    Reset_L = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    data_a = 4'h0; data_b = 4'h0;
    test_reset();
    test_single_a();
`ifdef MUX_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
`endif
    test_drop_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester arbiter and sequencer for the shared 4-bit 2:1 mux datapath. It grants one requester at a time for a bounded hold window and drives the mux select and enable. It also registers the selected 4-bit word with a valid strobe for downstream logic. It sits between the gate-level mux cells and any two producers sharing them.

## Interface
- HOLD_CYCLES, 2, maximum consecutive granted cycles per window; legal range 1..15
- WIDTH, 4, data width of each requester and of data_out
- clk  input  1  rising-edge clock
- Reset_L  input  1  asynchronous, active-low reset
- req_a  input  1  requester A wants the mux
- req_b  input  1  requester B wants the mux
- data_a  input  WIDTH  requester A word
- data_b  input  WIDTH  requester B word
- gnt_a  output  1  A owns the mux (registered)
- gnt_b  output  1  B owns the mux (registered)
- S4  output  1  mux select; 0 = A, 1 = B (registered)
- Reset_L4  output  1  mux enable, active-high; 1 while any grant is active (registered)
- data_out  output  WIDTH  captured word (registered)
- valid_out  output  1  data_out updated on the previous edge (registered)

## Operation
- States: IDLE, GRANT_A, GRANT_B. Internal 4-bit hold counter cnt. Internal last-grant flag last, reset to B so A wins the first tie.
- IDLE:
  - Only req_a → GRANT_A. Only req_b → GRANT_B.
  - Both requesting → grant the requester not equal to last.
  - Neither → stay. cnt = 0 on every entry into a grant state.
- GRANT_x, evaluated each edge in priority order:
  1. req_x low → release. Go to GRANT_other if the other is requesting, else IDLE.
  2. cnt == HOLD_CYCLES-1 → window expires. Go to GRANT_other if the other is requesting, else re-enter GRANT_x with cnt = 0.
  3. Otherwise cnt += 1.
- last updates to x on every entry into GRANT_x.
- Outputs are decoded from the registered state:
  - gnt_a = (state == GRANT_A), gnt_b = (state == GRANT_B), Reset_L4 = gnt_a | gnt_b.
  - S4 = 1 in GRANT_B, 0 in GRANT_A, holds its last value in IDLE.
- Capture:
  - On each edge where gnt_x = 1 and req_x = 1: data_out ← data_x, valid_out ← 1.
  - On any other edge: valid_out ← 0 and data_out holds.
- Reset (Reset_L = 0, asynchronous): state IDLE, cnt 0, last B, gnt_a 0, gnt_b 0, S4 0, Reset_L4 0, data_out 0, valid_out 0.
- Reset mid-grant aborts immediately. No capture occurs on the deassertion edge.

## Timing
- req → gnt: 1 cycle. A request sampled at edge N shows its grant after edge N.
- gnt → valid_out: 1 cycle. The word present at edge N+1 appears on data_out after edge N+1.
- Handover between requesters is zero-bubble: gnt_a falls and gnt_b rises on the same edge.
- gnt_a and gnt_b are never high together.
- Uninterrupted contention: each side receives exactly HOLD_CYCLES grant cycles, alternating.
- With HOLD_CYCLES = 1, alternation happens every cycle.
- A requester that drops req while granted gets no capture on that edge. The grant ends at that edge.

## Configuration
- MUX_ARB_FIXED_PRIO_EN defined:
  - A has fixed priority on ties in IDLE and at window expiry; last is ignored.
  - A held req_a continuously starves B.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset with req_a = req_b = 1, then release Reset_L → all outputs 0 during reset. gnt_a rises 1 edge after release.
- HOLD_CYCLES = 2, req_a only, data_a = 4'b1010 → gnt_a stays high continuously. valid_out = 1 from the 2nd edge on, data_out = 4'b1010, S4 = 0.
- HOLD_CYCLES = 2, req_a = req_b = 1 constant, data_a = 4'b0110, data_b = 4'b1001 → gnt pattern A,A,B,B,A,A. S4 follows 0,0,1,1,0,0. data_out follows one cycle later with no bubble.
- Granted A drops req_a after 1 cycle while req_b = 1 → gnt_b rises on the same edge gnt_a falls. valid_out shows no A capture for the dropped cycle.
- Reset_L pulsed low mid-GRANT_B → gnt_b, Reset_L4, valid_out and data_out go to 0 immediately, without waiting for clk. The next tie grants A.
- With MUX_ARB_FIXED_PRIO_EN and both requesting constantly → gnt_a is permanently high and gnt_b is never asserted.
